hc_dec_pipe: RTL

Pipelined Hamming single-error-correcting decoder that sits directly downstream of the Hamming encoder `hc_enc` and its channel. It accepts one encoded codeword per cycle over a valid/ready handshake and computes the syndrome. It corrects any single-bit error, strips the check bits and delivers the recovered data word downstream with error status. Saturating event counters give the system a running view of channel quality.

---
 rtl/hc_pkg.sv | 46 ++++
 rtl/hc_syn.sv | 25 ++
 rtl/hc_dec_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hc_pkg.sv
// Shared Hamming code layout helpers for the encoder and decoder.
// Positions are 1-based; position p lives at codeword bit p-1.
package hc_pkg;

    // Error status attached to each decoded word.
    typedef struct packed {
        logic corr;
        logic uncorr;
    } err_flags_t;

    // Total codeword width for a given data/check split.
    function automatic int num_pos(input int data_wd, input int chk_wd);
        return data_wd + chk_wd;
    endfunction

    // Power-of-two positions carry check bits.
    function automatic bit is_chk_pos(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data index carried at a non-check position p.
    function automatic int data_idx(input int p);
        int idx;
        idx = 0;
        for (int q = 1; q < 64; q++) begin
            if (q < p && !is_chk_pos(q)) idx++;
        end
        return idx;
    endfunction

    // Position that carries data bit i.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 64; p++) begin
            if (!is_chk_pos(p)) begin
                if (cnt == i && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hc_syn.sv
// Combinational syndrome generator: bit i is the XOR of every codeword
// bit whose position has bit i set, check bits included.
module hc_syn
    import hc_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3
) (
    input  logic [DATA_WD+CHK_WD-1:0] cw,
    output logic [CHK_WD-1:0]         syn
);

    localparam int N = num_pos(DATA_WD, CHK_WD);

    // Parity over each position class.
    always_comb begin
        syn = '0;
        for (int i = 0; i < CHK_WD; i++) begin
            for (int p = 1; p <= N; p++) begin
                if (((p >> i) & 1) == 1) syn[i] = syn[i] ^ cw[p-1];
            end
        end
    end

endmodule

// File: rtl/hc_dec_pipe.sv
// Two-stage pipelined Hamming SEC decoder with saturating error counters.
//
// Handshake: a word moves across a boundary on a clock edge where the
// sender's valid and the receiver's ready are both high. Valid never
// depends on ready; once raised, valid and payload hold until taken.
// Each stage loads when it is empty or its contents move on this edge,
// so o_rdy is combinational from i_rdy and the pipe runs bubble-free.
module hc_dec_pipe
    import hc_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3,
    parameter int CNT_WD  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [DATA_WD+CHK_WD-1:0] i_enc_data,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [DATA_WD-1:0]        o_data,
    output logic [CHK_WD-1:0]         o_syn,
    output logic                      o_corr,
    output logic                      o_uncorr,
    input  logic                      i_clr_cnt,
    output logic [CNT_WD-1:0]         o_corr_cnt,
    output logic [CNT_WD-1:0]         o_uncorr_cnt
);

    localparam int N = num_pos(DATA_WD, CHK_WD);

    if (2**CHK_WD < DATA_WD + CHK_WD + 1) begin : g_bad_cfg
        $fatal(1, "hc_dec_pipe: CHK_WD too small for DATA_WD");
    end

    // Stage 1: received codeword and its syndrome.
    logic             s1_vld;
    logic [N-1:0]     s1_cw;
    logic [CHK_WD-1:0] s1_syn;
    logic [CHK_WD-1:0] in_syn;

    // Stage 2: corrected data and status.
    logic               s2_vld;
    logic [DATA_WD-1:0] s2_data;
    logic [CHK_WD-1:0]  s2_syn;
    err_flags_t         s2_flags;

    logic               s1_load;
    logic               s2_load;
    logic               out_hs;
    logic [N-1:0]       fixed_cw;
    logic [DATA_WD-1:0] fixed_data;
    err_flags_t         fixed_flags;
    logic [CNT_WD-1:0]  corr_cnt;
    logic [CNT_WD-1:0]  uncorr_cnt;

    hc_syn #(
        .DATA_WD(DATA_WD),
        .CHK_WD (CHK_WD)
    ) u_syn (
        .cw (i_enc_data),
        .syn(in_syn)
    );

    // Stage load enables and the output handshake.
    always_comb begin
        s2_load = !s2_vld || i_rdy;
        s1_load = !s1_vld || s2_load;
        out_hs  = s2_vld && i_rdy;
    end

    assign o_rdy = s1_load;

    // Stage 1 register: capture the codeword and its syndrome on input handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld <= 1'b0;
            s1_cw  <= '0;
            s1_syn <= '0;
        end else if (s1_load) begin
            s1_vld <= i_vld;
            if (i_vld) begin
                s1_cw  <= i_enc_data;
                s1_syn <= in_syn;
            end
        end
    end

    // Flip the bit the syndrome points at, then strip the check bits.
    always_comb begin
        fixed_cw    = s1_cw;
        fixed_data  = '0;
        fixed_flags = '{corr: 1'b0, uncorr: 1'b0};
        if (int'(s1_syn) > N) begin
            fixed_flags.uncorr = 1'b1;
        end else if (s1_syn != '0) begin
            fixed_flags.corr = 1'b1;
            for (int p = 1; p <= N; p++) begin
                if (int'(s1_syn) == p) fixed_cw[p-1] = ~fixed_cw[p-1];
            end
        end
        for (int p = 1; p <= N; p++) begin
            if (!is_chk_pos(p)) fixed_data[data_idx(p)] = fixed_cw[p-1];
        end
    end

    // Stage 2 register: hold corrected word until downstream takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld   <= 1'b0;
            s2_data  <= '0;
            s2_syn   <= '0;
            s2_flags <= '{corr: 1'b0, uncorr: 1'b0};
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data  <= fixed_data;
                s2_syn   <= s1_syn;
                s2_flags <= fixed_flags;
            end
        end
    end

    // Saturating event counters; clear has priority over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (i_clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (s2_flags.corr && corr_cnt != {CNT_WD{1'b1}})
                corr_cnt <= corr_cnt + CNT_WD'(1);
            if (s2_flags.uncorr && uncorr_cnt != {CNT_WD{1'b1}})
                uncorr_cnt <= uncorr_cnt + CNT_WD'(1);
        end
    end

    assign o_vld        = s2_vld;
    assign o_data       = s2_data;
    assign o_syn        = s2_syn;
    assign o_corr       = s2_flags.corr;
    assign o_uncorr     = s2_flags.uncorr;
    assign o_corr_cnt   = corr_cnt;
    assign o_uncorr_cnt = uncorr_cnt;

endmodule
